// File: rtl/vending_machine_param.sv
// Parametrised vending-machine controller: coin credit, priced products,
// exact change value. Optional stock counters: define VM_STOCK_EN.
module vending_machine_param #(
  parameter int NUM_PRODUCTS = 4,
  parameter int SEL_W = 2,
  parameter int CREDIT_W = 8,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES =
    {8'd20, 8'd15, 8'd10, 8'd5},
  parameter int MAX_CREDIT = 100,
  parameter int STOCK_INIT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              coin,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    sel_valid,
  input  logic                    cancel,
  output logic [NUM_PRODUCTS-1:0] vend,
  output logic                    change_valid,
  output logic [CREDIT_W-1:0]     change_amt,
  output logic [CREDIT_W-1:0]     credit,
  output logic                    coin_reject,
  output logic                    deny,
  output logic                    busy,
  output logic [NUM_PRODUCTS-1:0] sold_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CREDIT = 2'd1;
  localparam logic [1:0] S_DISP   = 2'd2;
  localparam logic [1:0] S_REFUND = 2'd3;

  localparam logic [CREDIT_W:0] MAX_C =
    (CREDIT_W+1)'(MAX_CREDIT);

  if (NUM_PRODUCTS < 2 ||
      (2 ** SEL_W) < NUM_PRODUCTS ||
      MAX_CREDIT >= (2 ** CREDIT_W) ||
      STOCK_INIT < 0) begin : g_bad_cfg
    $error("vending_machine_param: bad parameters");
  end

  logic [1:0]              state_q, state_d;
  logic [CREDIT_W-1:0]     credit_q, credit_d;
  logic [CREDIT_W-1:0]     amt_q, amt_d;
  logic [NUM_PRODUCTS-1:0] vend_q, vend_d;
  logic                    chg_v_q, chg_v_d;
  logic [CREDIT_W-1:0]     chg_amt_q, chg_amt_d;
  logic                    rej_q, rej_d;
  logic                    deny_q, deny_d;
  logic                    busy_q, busy_d;

  logic [CREDIT_W:0]       coin_val;
  logic [CREDIT_W:0]       coin_sum;
  logic                    coin_fits;
  logic                    coin_any;
  logic [CREDIT_W-1:0]     price;
  logic                    sel_ok;
  logic                    sel_empty;
  logic                    can_buy;
  logic [CREDIT_W-1:0]     remainder;
  logic                    ready;
  logic                    accept;
  logic [NUM_PRODUCTS-1:0] empty;

  // Decode coin value, selected price and purchase eligibility.
  always_comb begin
    case (coin)
      2'b01:   coin_val = (CREDIT_W+1)'(5);
      2'b10:   coin_val = (CREDIT_W+1)'(10);
      2'b11:   coin_val = (CREDIT_W+1)'(20);
      default: coin_val = '0;
    endcase
    coin_any  = coin != 2'b00;
    coin_sum  = {1'b0, credit_q} + coin_val;
    coin_fits = coin_sum <= MAX_C;
    price     = '0;
    sel_ok    = 1'b0;
    sel_empty = 1'b0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_ok    = 1'b1;
        price     = PRICES[i*CREDIT_W +: CREDIT_W];
        sel_empty = empty[i];
      end
    end
    can_buy   = sel_ok && (credit_q >= price) &&
                !sel_empty;
    remainder = credit_q - price;
    ready     = (state_q == S_IDLE) ||
                (state_q == S_CREDIT);
    accept    = ready && !cancel && sel_valid &&
                can_buy;
  end

  // Next-state and next-output logic of the controller.
  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    amt_d     = amt_q;
    vend_d    = '0;
    chg_v_d   = 1'b0;
    chg_amt_d = '0;
    rej_d     = 1'b0;
    deny_d    = 1'b0;
    busy_d    = 1'b0;
    unique case (state_q)
      S_IDLE, S_CREDIT: begin
        if (cancel) begin
          rej_d = coin_any;
          if (credit_q != '0) begin
            state_d   = S_REFUND;
            chg_v_d   = 1'b1;
            chg_amt_d = credit_q;
            busy_d    = 1'b1;
          end
        end else if (sel_valid) begin
          rej_d = coin_any;
          if (can_buy) begin
            state_d = S_DISP;
            amt_d   = remainder;
            busy_d  = 1'b1;
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
              vend_d[i] = (sel == SEL_W'(i));
            end
          end else begin
            deny_d = 1'b1;
          end
        end else if (coin_any) begin
          if (coin_fits) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = S_CREDIT;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      S_DISP: begin
        rej_d = coin_any;
        if (amt_q != '0) begin
          state_d   = S_REFUND;
          chg_v_d   = 1'b1;
          chg_amt_d = amt_q;
          busy_d    = 1'b1;
        end else begin
          state_d  = S_IDLE;
          credit_d = '0;
        end
      end
      S_REFUND: begin
        rej_d    = coin_any;
        state_d  = S_IDLE;
        credit_d = '0;
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
      end
    endcase
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      credit_q  <= '0;
      amt_q     <= '0;
      vend_q    <= '0;
      chg_v_q   <= 1'b0;
      chg_amt_q <= '0;
      rej_q     <= 1'b0;
      deny_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      amt_q     <= amt_d;
      vend_q    <= vend_d;
      chg_v_q   <= chg_v_d;
      chg_amt_q <= chg_amt_d;
      rej_q     <= rej_d;
      deny_q    <= deny_d;
      busy_q    <= busy_d;
    end
  end

`ifdef VM_STOCK_EN
  localparam int STK_W =
    (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;

  logic [STK_W-1:0]        stock_q [NUM_PRODUCTS];
  logic [STK_W-1:0]        stock_d [NUM_PRODUCTS];
  logic [NUM_PRODUCTS-1:0] sold_q, sold_d;

  // Take one unit from the product at the moment it is accepted,
  // so its empty flag rises together with the vend pulse.
  always_comb begin
    stock_d = stock_q;
    sold_d  = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (accept && (sel == SEL_W'(i)) &&
          (stock_q[i] != '0)) begin
        stock_d[i] = stock_q[i] - STK_W'(1);
      end
      sold_d[i] = (stock_d[i] == '0);
    end
  end

  // Stock counters and registered empty flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
        stock_q[i] <= STK_W'(STOCK_INIT);
      end
      sold_q <= '0;
    end else begin
      stock_q <= stock_d;
      sold_q  <= sold_d;
    end
  end

  assign empty    = sold_q;
  assign sold_out = sold_q;
`else
  assign empty    = '0;
  assign sold_out = '0;
`endif

  assign vend         = vend_q;
  assign change_valid = chg_v_q;
  assign change_amt   = chg_amt_q;
  assign credit       = credit_q;
  assign coin_reject  = rej_q;
  assign deny         = deny_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Bench for vending_machine_param: directed scenarios plus random
// traffic, compared every cycle against a transaction-level model.
module tb_vending_machine_param;

  localparam int NP   = 4;
  localparam int SW   = 2;
  localparam int CW   = 8;
  localparam int MAXC = 100;
  localparam int STK  = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    coin = 2'b00;
  logic [SW-1:0] sel = '0;
  logic          sel_valid = 1'b0;
  logic          cancel = 1'b0;
  logic [NP-1:0] vend;
  logic          change_valid;
  logic [CW-1:0] change_amt;
  logic [CW-1:0] credit;
  logic          coin_reject;
  logic          deny;
  logic          busy;
  logic [NP-1:0] sold_out;

  always #5 clk = ~clk;

  vending_machine_param #(
    .NUM_PRODUCTS(NP),
    .SEL_W(SW),
    .CREDIT_W(CW),
    .PRICES({8'd20, 8'd15, 8'd10, 8'd5}),
    .MAX_CREDIT(MAXC),
    .STOCK_INIT(STK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .coin(coin),
    .sel(sel),
    .sel_valid(sel_valid),
    .cancel(cancel),
    .vend(vend),
    .change_valid(change_valid),
    .change_amt(change_amt),
    .credit(credit),
    .coin_reject(coin_reject),
    .deny(deny),
    .busy(busy),
    .sold_out(sold_out)
  );

  typedef struct packed {
    logic [NP-1:0] vend;
    logic          cv;
    logic [CW-1:0] amt;
    logic [CW-1:0] credit;
    logic          rej;
    logic          deny;
    logic          busy;
    logic [NP-1:0] sold;
  } exp_t;

  int   price_tab [NP] = '{5, 10, 15, 20};
  int   m_credit;
  bit   m_busy;
  int   pend [$];
  int   m_stock [NP];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               nm, act, req, $time);
    end
  endtask

  function automatic int coin_value(input logic [1:0] c);
    case (c)
      2'b01:   return 5;
      2'b10:   return 10;
      2'b11:   return 20;
      default: return 0;
    endcase
  endfunction

  // Transaction-level model: a purchase schedules its busy cycles
  // (vend, then optional change) and credit empties when they end.
  task automatic model_step();
    int v;
    int p;
    bit empty_p;
    e = '0;
    if (rst) begin
      m_credit = 0;
      m_busy   = 0;
      pend.delete();
      for (int i = 0; i < NP; i++) m_stock[i] = STK;
    end else if (m_busy) begin
      e.rej = (coin != 2'b00);
      if (pend.size() > 0) begin
        e.cv     = 1'b1;
        e.amt    = CW'(pend.pop_front());
        e.busy   = 1'b1;
        e.credit = CW'(m_credit);
      end else begin
        m_credit = 0;
        m_busy   = 0;
      end
    end else begin
      e.credit = CW'(m_credit);
      if (cancel) begin
        e.rej = (coin != 2'b00);
        if (m_credit > 0) begin
          e.cv   = 1'b1;
          e.amt  = CW'(m_credit);
          e.busy = 1'b1;
          m_busy = 1;
        end
      end else if (sel_valid) begin
        e.rej = (coin != 2'b00);
        empty_p = 0;
`ifdef VM_STOCK_EN
        if (int'(sel) < NP) empty_p = (m_stock[sel] == 0);
`endif
        p = (int'(sel) < NP) ? price_tab[sel] : 0;
        if (int'(sel) < NP && m_credit >= p && !empty_p) begin
          e.vend = NP'(1) << sel;
          e.busy = 1'b1;
          m_busy = 1;
          if (m_credit - p > 0) pend.push_back(m_credit - p);
          m_stock[sel] = m_stock[sel] - 1;
        end else begin
          e.deny = 1'b1;
        end
      end else if (coin != 2'b00) begin
        v = coin_value(coin);
        if (m_credit + v <= MAXC) m_credit += v;
        else e.rej = 1'b1;
        e.credit = CW'(m_credit);
      end
    end
`ifdef VM_STOCK_EN
    if (!rst) begin
      for (int i = 0; i < NP; i++) e.sold[i] = (m_stock[i] == 0);
    end
`endif
  endtask

  task automatic compare_all();
    chk("vend", vend, e.vend);
    chk("change_valid", change_valid, e.cv);
    chk("change_amt", change_amt, e.amt);
    chk("credit", credit, e.credit);
    chk("coin_reject", coin_reject, e.rej);
    chk("deny", deny, e.deny);
    chk("busy", busy, e.busy);
    chk("sold_out", sold_out, e.sold);
  endtask

  task automatic cycle(input logic [1:0] c, input int s,
                       input bit sv, input bit cn, input bit r);
    coin      = c;
    sel       = SW'(s);
    sel_valid = sv;
    cancel    = cn;
    rst       = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    cycle(2'b00, 0, 0, 0, 1);
    cycle(2'b00, 0, 0, 0, 1);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_credit", credit, 0);
    chk("rst_outs", {vend, change_valid, coin_reject, deny, busy}, 0);
    chk("rst_sold", sold_out, 0);

    // exact payment
    cycle(2'b01, 0, 0, 0, 0);
    chk("exact_credit", credit, 5);
    cycle(2'b00, 0, 1, 0, 0);
    chk("exact_vend", vend, 4'b0001);
    chk("exact_hold", credit, 5);
    cycle(2'b00, 0, 0, 0, 0);
    chk("exact_nochg", change_valid, 0);
    chk("exact_zero", credit, 0);

    // overpayment
    do_reset();
    cycle(2'b01, 0, 0, 0, 0);
    cycle(2'b10, 0, 0, 0, 0);
    chk("over_credit", credit, 15);
    cycle(2'b00, 0, 1, 0, 0);
    chk("over_vend", vend, 4'b0001);
    cycle(2'b00, 0, 0, 0, 0);
    chk("over_cv", change_valid, 1);
    chk("over_amt", change_amt, 10);
    cycle(2'b00, 0, 0, 0, 0);
    chk("over_idle", credit, 0);

    // denial then cancel beating a selection
    do_reset();
    cycle(2'b10, 0, 0, 0, 0);
    cycle(2'b00, 3, 1, 0, 0);
    chk("deny_pulse", deny, 1);
    chk("deny_keep", credit, 10);
    cycle(2'b00, 0, 1, 1, 0);
    chk("cancel_amt", change_amt, 10);
    chk("cancel_novend", vend, 0);
    cycle(2'b00, 0, 0, 0, 0);
    chk("cancel_idle", credit, 0);

    // ceiling and coin during dispense
    do_reset();
    cycle(2'b10, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(2'b11, 0, 0, 0, 0);
    chk("ceil_credit", credit, 90);
    cycle(2'b11, 0, 0, 0, 0);
    chk("ceil_reject", coin_reject, 1);
    chk("ceil_keep", credit, 90);
    cycle(2'b00, 0, 1, 0, 0);
    cycle(2'b01, 0, 0, 0, 0);
    chk("disp_reject", coin_reject, 1);
    chk("disp_amt", change_amt, 85);
    cycle(2'b00, 0, 0, 0, 0);
    chk("ceil_idle", credit, 0);

`ifdef VM_STOCK_EN
    do_reset();
    cycle(2'b10, 0, 0, 0, 0);
    cycle(2'b00, 1, 1, 0, 0);
    chk("stk_vend", vend, 4'b0010);
    chk("stk_sold", sold_out[1], 1);
    cycle(2'b00, 0, 0, 0, 0);
    cycle(2'b10, 0, 0, 0, 0);
    cycle(2'b00, 1, 1, 0, 0);
    chk("stk_deny", deny, 1);
    chk("stk_keep", credit, 10);
`endif

    // random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(1) == 0) ? 2'b00
                                     : 2'($urandom_range(3)),
            int'($urandom_range(NP - 1)),
            $urandom_range(4) == 0,
            $urandom_range(11) == 0,
            $urandom_range(99) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vending_machine_param.md
# vending_machine_param

Parametrised vending-machine controller, successor to the fixed three-product, two-coin machine. It accumulates credit from coded coin inputs up to a configurable ceiling and dispenses any of `NUM_PRODUCTS` products at per-product prices. It returns the exact change amount as a value rather than a flag, and supports cancel, denial and coin-rejection reporting. It sits directly behind the coin acceptor and keypad decoders and drives the dispenser and change-hopper interfaces.

## Interface
Parameters:
- `NUM_PRODUCTS`, 4: number of products; must be at least 2.
- `SEL_W`, 2: selection index width; must satisfy 2^`SEL_W` >= `NUM_PRODUCTS`.
- `CREDIT_W`, 8: width of credit, price and change values.
- `PRICES`, {8'd20,8'd15,8'd10,8'd5}: packed per-product prices, product 0 in the LSBs. Each price is `CREDIT_W` bits and nonzero.
- `MAX_CREDIT`, 100: credit ceiling; must be below 2^`CREDIT_W`.
- `STOCK_INIT`, 3: initial per-product stock; used only with `VM_STOCK_EN`.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `coin`  in  2  coin code: 00 none, 01 Rs5, 10 Rs10, 11 Rs20. A nonzero code is one coin per cycle.
- `sel`  in  `SEL_W`  product index; valid only with `sel_valid`.
- `sel_valid`  in  1  purchase request strobe.
- `cancel`  in  1  refund request strobe.
- `vend`  out  `NUM_PRODUCTS`  one-hot dispense pulse.
- `change_valid`  out  1  change pulse.
- `change_amt`  out  `CREDIT_W`  change value; meaningful only while `change_valid`=1, 0 otherwise.
- `credit`  out  `CREDIT_W`  current registered credit.
- `coin_reject`  out  1  pulse: the coin is returned and not credited.
- `deny`  out  1  pulse: the request was refused.
- `busy`  out  1  high in DISPENSE and REFUND.
- `sold_out`  out  `NUM_PRODUCTS`  per-product empty flags.

## Operation
States:
- IDLE: credit is 0.
- CREDIT: credit is greater than 0.
- DISPENSE: one cycle.
- REFUND: one cycle.

In IDLE and CREDIT, the first matching rule applies each cycle (priority cancel > sel_valid > coin):
- `cancel`: if credit > 0, go to REFUND with refund amount = credit. If credit = 0, there is no response.
- `sel_valid`: the request is accepted when `sel` < `NUM_PRODUCTS`, credit >= PRICES[`sel`], and the product is not sold out. On acceptance, go to DISPENSE and latch remainder = credit − price. Otherwise pulse `deny` next cycle; credit and state are unchanged.
- `coin` nonzero: if credit + value <= `MAX_CREDIT`, add value to credit (IDLE moves to CREDIT). Otherwise pulse `coin_reject` and leave credit unchanged.

Other states and rules:
- A coin presented in the same cycle as an accepted cancel or sel, or during DISPENSE/REFUND, is rejected (`coin_reject` pulse).
- `sel_valid` and `cancel` during DISPENSE/REFUND are ignored; no `deny` is raised.
- DISPENSE: `vend[sel]`=1 for one cycle. Next state is REFUND if remainder > 0, else IDLE with credit 0.
- REFUND: `change_valid`=1 and `change_amt`=amount for one cycle, then IDLE with credit 0.
- Arithmetic is unsigned at `CREDIT_W` bits. The ceiling check uses `CREDIT_W`+1 bits, so credit never wraps.

## Timing
- All outputs are registered.
- Reset value is 0 for `vend`, `change_valid`, `change_amt`, `credit`, `coin_reject`, `deny` and `busy`, and state is IDLE. `sold_out` resets to 0 (with `VM_STOCK_EN`, stock resets to `STOCK_INIT`).
- A coin sampled at edge N is visible on `credit` after edge N.
- An accepted sel at edge N gives `vend` high during cycle N+1 and `change_valid` during N+2 if there is change.
- Cancel at edge N gives `change_valid` during N+1.
- `deny` and `coin_reject` are high during the cycle after the offending edge.
- `credit` keeps its pre-purchase value during DISPENSE and REFUND and reads 0 on return to IDLE.
- Reset asserted mid-DISPENSE or mid-REFUND aborts without a pulse on the next cycle; credit is lost.

## Configuration
- `VM_STOCK_EN` defined: adds per-product stock counters, width clog2(`STOCK_INIT`+1).
  - Each `vend` pulse decrements the stock of that product.
  - `sold_out[i]` = (stock[i] == 0).
  - Selecting a sold-out product gives `deny`, and credit is kept.
- `VM_STOCK_EN` undefined: stock is unlimited, `sold_out` is tied to 0, and no counters are built.

## Test plan
- Reset: hold `rst` 2 cycles -> all outputs 0, `credit`=0, `sold_out`=0.
- Exact payment: coin 01, then `sel`=0 -> `credit`=5, `vend`=0001 for one cycle, no `change_valid`, `credit`=0.
- Overpayment: coins 01, 10 (`credit`=15), `sel`=0 -> `vend`=0001, then `change_valid` with `change_amt`=10, then IDLE.
- Cancel and denial: coin 10, `sel`=3 -> `deny`, `credit` stays 10. Then `cancel` with `sel_valid` in the same cycle -> cancel wins, `change_amt`=10, no `vend`.
- Ceiling: coin 10, then four coin 11 -> `credit`=90. A fifth coin 11 -> `coin_reject`, `credit`=90. A coin during DISPENSE is rejected.
- Stock (`VM_STOCK_EN`, `STOCK_INIT`=1): buy product 1 twice with 10 each -> the first gives `vend`=0010 and `sold_out[1]`=1. The second gives `deny` with `credit`=10 retained.
